// File: rtl/cpu_system.sv
// Single-bus 32-bit datapath with externally sequenced control and a 512x32 unified memory.
// Optional signed multiplier on opcode 01111 is built only when SYSTEM_MUL_EN is defined.
module cpu_system #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  Clock,
  input  logic                  clear,
  input  logic                  HIout,
  input  logic                  LOout,
  input  logic                  Zhi_out,
  input  logic                  Zlo_out,
  input  logic                  PCout,
  input  logic                  MDRout,
  input  logic                  Inport_out,
  input  logic                  Cout,
  input  logic                  Rout,
  input  logic                  BAout,
  input  logic                  MARin,
  input  logic                  Zin,
  input  logic                  PCin,
  input  logic                  MDRin,
  input  logic                  IRin,
  input  logic                  Yin,
  input  logic                  HIin,
  input  logic                  LOin,
  input  logic                  CONin,
  input  logic                  Rin,
  input  logic                  outport_in,
  input  logic                  Gra,
  input  logic                  Grb,
  input  logic                  Grc,
  input  logic [4:0]            opcode,
  input  logic                  IncPC,
  input  logic [DATA_WIDTH-1:0] inport_data,
  input  logic                  inport_data_ready,
  output logic [DATA_WIDTH-1:0] outport_data,
  input  logic                  Mem_Read,
  input  logic                  Mem_Write,
  input  logic                  Mem_enable512x32,
  output logic [DATA_WIDTH-1:0] Mem_to_datapath_out,
  output logic [DATA_WIDTH-1:0] Mem_data_to_chip_out,
  output logic [ADDR_WIDTH-1:0] MAR_address_out,
  output logic                  memory_done,
  output logic                  con_ff_bit,
  input  logic                  mem_overide,
  input  logic [ADDR_WIDTH-1:0] overide_address,
  input  logic [DATA_WIDTH-1:0] overide_data_in
);

  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_AND = 5'b00101;
  localparam logic [4:0] OP_OR  = 5'b00110;
  localparam logic [4:0] OP_SHR = 5'b00111;
  localparam logic [4:0] OP_SHL = 5'b01000;
`ifdef SYSTEM_MUL_EN
  localparam logic [4:0] OP_MUL = 5'b01111;
`endif
  localparam logic [DATA_WIDTH-1:0] ONE = 1;

  logic [DATA_WIDTH-1:0] r_file [16];
  logic [DATA_WIDTH-1:0] pc, ir, y, mdr, hi, lo, zhi, zlo, inport, outport;
  logic [ADDR_WIDTH-1:0] mar;
  logic                  con, mem_done;

  logic [DATA_WIDTH-1:0] mem [1<<ADDR_WIDTH];

  logic [DATA_WIDTH-1:0] bus, rout_val, c_sext, mem_rdata, mem_wdata;
  logic [DATA_WIDTH-1:0] alu_hi, alu_lo;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            sel;
  logic                  con_next;
  logic                  unused_ir;

  assign unused_ir = ^ir[DATA_WIDTH-1:27];

  assign sel      = ({4{Gra}} & ir[26:23]) | ({4{Grb}} & ir[22:19]) | ({4{Grc}} & ir[18:15]);
  assign rout_val = (BAout && sel == 4'd0) ? '0 : r_file[sel];
  assign c_sext   = {{(DATA_WIDTH-19){ir[18]}}, ir[18:0]};

  always_comb begin
    bus = '0;
    if      (Zlo_out)    bus = zlo;
    else if (Zhi_out)    bus = zhi;
    else if (HIout)      bus = hi;
    else if (LOout)      bus = lo;
    else if (PCout)      bus = pc;
    else if (MDRout)     bus = mdr;
    else if (Inport_out) bus = inport;
    else if (Cout)       bus = c_sext;
    else if (Rout)       bus = rout_val;
  end

`ifdef SYSTEM_MUL_EN
  logic [2*DATA_WIDTH-1:0] prod;
  // Sign-extend both operands so the low 64 bits of the product are the signed result.
  assign prod = {{DATA_WIDTH{y[DATA_WIDTH-1]}}, y} * {{DATA_WIDTH{bus[DATA_WIDTH-1]}}, bus};
`endif

  always_comb begin
    alu_hi = '0;
    alu_lo = y + bus;
    if (IncPC) begin
      alu_lo = bus + ONE;
    end else begin
      case (opcode)
        OP_SUB:  alu_lo = y - bus;
        OP_AND:  alu_lo = y & bus;
        OP_OR:   alu_lo = y | bus;
        OP_SHR:  alu_lo = y >> bus[4:0];
        OP_SHL:  alu_lo = y << bus[4:0];
`ifdef SYSTEM_MUL_EN
        OP_MUL:  {alu_hi, alu_lo} = prod;
`endif
        default: alu_lo = y + bus;
      endcase
    end
  end

  always_comb begin
    con_next = 1'b0;
    case (ir[20:19])
      2'b00:   con_next = (bus == '0);
      2'b01:   con_next = (bus != '0);
      2'b10:   con_next = ~bus[DATA_WIDTH-1];
      default: con_next = bus[DATA_WIDTH-1];
    endcase
  end

  assign mem_addr  = mem_overide ? overide_address : mar;
  assign mem_wdata = mem_overide ? overide_data_in : mdr;
  assign mem_rdata = (Mem_enable512x32 && Mem_Read) ? mem[mem_addr] : '0;

  // Memory contents survive clear, so the array has no reset branch.
  always_ff @(posedge Clock) begin
    if (Mem_enable512x32 && (Mem_Write || mem_overide)) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < 16; i++) r_file[i] <= '0;
      pc       <= '0;
      ir       <= '0;
      y        <= '0;
      mar      <= '0;
      mdr      <= '0;
      hi       <= '0;
      lo       <= '0;
      zhi      <= '0;
      zlo      <= '0;
      inport   <= '0;
      outport  <= '0;
      con      <= 1'b0;
      mem_done <= 1'b0;
    end else begin
      if (Rin)               r_file[sel] <= bus;
      if (PCin)              pc          <= bus;
      if (IRin)              ir          <= bus;
      if (Yin)               y           <= bus;
      if (MARin)             mar         <= bus[ADDR_WIDTH-1:0];
      if (MDRin)             mdr         <= Mem_Read ? mem_rdata : bus;
      if (HIin)              hi          <= bus;
      if (LOin)              lo          <= bus;
      if (Zin)               {zhi, zlo}  <= {alu_hi, alu_lo};
      if (inport_data_ready) inport      <= inport_data;
      if (outport_in)        outport     <= bus;
      if (CONin)             con         <= con_next;
      mem_done <= Mem_enable512x32;
    end
  end

  assign outport_data         = outport;
  assign Mem_to_datapath_out  = mem_rdata;
  assign Mem_data_to_chip_out = mem_wdata;
  assign MAR_address_out      = mar;
  assign memory_done          = mem_done;
  assign con_ff_bit           = con;

endmodule

// File: tb/tb_cpu_system.sv
// Randomized self-checking bench for cpu_system against a behavioural model of the datapath rules.
module tb_cpu_system;

  logic        Clock, clear;
  logic        HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout, Rout, BAout;
  logic        MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, Rin, outport_in;
  logic        Gra, Grb, Grc, IncPC, inport_data_ready;
  logic [4:0]  opcode;
  logic [31:0] inport_data, outport_data;
  logic        Mem_Read, Mem_Write, Mem_enable512x32;
  logic [31:0] Mem_to_datapath_out, Mem_data_to_chip_out;
  logic [8:0]  MAR_address_out;
  logic        memory_done, con_ff_bit;
  logic        mem_overide;
  logic [8:0]  overide_address;
  logic [31:0] overide_data_in;

  int checks = 0;
  int errors = 0;
  logic [31:0] mmem [512];

  cpu_system dut (
    .Clock(Clock), .clear(clear),
    .HIout(HIout), .LOout(LOout), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out), .PCout(PCout),
    .MDRout(MDRout), .Inport_out(Inport_out), .Cout(Cout), .Rout(Rout), .BAout(BAout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .CONin(CONin), .Rin(Rin), .outport_in(outport_in),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .opcode(opcode), .IncPC(IncPC),
    .inport_data(inport_data), .inport_data_ready(inport_data_ready),
    .outport_data(outport_data),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Mem_enable512x32(Mem_enable512x32),
    .Mem_to_datapath_out(Mem_to_datapath_out), .Mem_data_to_chip_out(Mem_data_to_chip_out),
    .MAR_address_out(MAR_address_out), .memory_done(memory_done), .con_ff_bit(con_ff_bit),
    .mem_overide(mem_overide), .overide_address(overide_address), .overide_data_in(overide_data_in)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    {HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout, Rout, BAout} = '0;
    {MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, Rin, outport_in} = '0;
    {Gra, Grb, Grc, IncPC, inport_data_ready} = '0;
    {Mem_Read, Mem_Write, Mem_enable512x32, mem_overide} = '0;
    opcode = 5'd0;
    overide_address = '0;
    overide_data_in = '0;
  endtask

  task automatic put_inport(input logic [31:0] v);
    inport_data = v; inport_data_ready = 1'b1; tick(); idle();
  endtask

  task automatic set_ir(input logic [31:0] v);
    put_inport(v); Inport_out = 1'b1; IRin = 1'b1; tick(); idle();
  endtask

  task automatic set_pc(input logic [31:0] v);
    put_inport(v); Inport_out = 1'b1; PCin = 1'b1; tick(); idle();
  endtask

  task automatic set_mar(input logic [31:0] v);
    put_inport(v); Inport_out = 1'b1; MARin = 1'b1; tick(); idle();
  endtask

  task automatic write_reg(input logic [3:0] idx, input logic [31:0] v);
    set_ir({5'b0, idx, 23'b0});
    put_inport(v); Inport_out = 1'b1; Gra = 1'b1; Rin = 1'b1; tick(); idle();
  endtask

  task automatic read_reg(input logic [3:0] idx, output logic [31:0] v);
    set_ir({5'b0, idx, 23'b0});
    Gra = 1'b1; Rout = 1'b1; outport_in = 1'b1; tick(); idle();
    v = outport_data;
  endtask

  function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a; sb = b;
    case (op)
      5'd4:  return {32'h0, a - b};
      5'd5:  return {32'h0, a & b};
      5'd6:  return {32'h0, a | b};
      5'd7:  return {32'h0, a >> b[4:0]};
      5'd8:  return {32'h0, a << b[4:0]};
`ifdef SYSTEM_MUL_EN
      5'd15: return 64'(longint'(sa) * longint'(sb));
`endif
      default: return {32'h0, a + b};
    endcase
  endfunction

  task automatic test_reset();
    clear = 1'b0; idle(); inport_data = '0;
    #12;
    checks++; if (outport_data !== 32'h0) begin errors++; $display("FAIL reset_outport got %h expected 0", outport_data); end
    checks++; if (MAR_address_out !== 9'h0) begin errors++; $display("FAIL reset_mar got %h expected 0", MAR_address_out); end
    checks++; if (memory_done !== 1'b0) begin errors++; $display("FAIL reset_memory_done got %b expected 0", memory_done); end
    checks++; if (con_ff_bit !== 1'b0) begin errors++; $display("FAIL reset_con got %b expected 0", con_ff_bit); end
    checks++; if (Mem_to_datapath_out !== 32'h0) begin errors++; $display("FAIL reset_mem_rd got %h expected 0", Mem_to_datapath_out); end
    clear = 1'b1;
    tick();
  endtask

  task automatic test_preload();
    logic [8:0]  addr [6];
    logic [31:0] data [6];
    addr[0] = 9'd0;   data[0] = 32'h18900001;
    addr[1] = 9'd500; data[1] = 32'h14;
    for (int i = 2; i < 6; i++) begin
      addr[i] = 9'(100 + 50 * i + $urandom_range(0, 40));
      data[i] = $urandom;
    end
    for (int i = 0; i < 6; i++) begin
      mem_overide = 1'b1; Mem_enable512x32 = 1'b1;
      overide_address = addr[i]; overide_data_in = data[i];
      #1;
      checks++; if (Mem_data_to_chip_out !== data[i]) begin errors++; $display("FAIL ovr_wdata got %h expected %h", Mem_data_to_chip_out, data[i]); end
      tick(); idle();
      mmem[addr[i]] = data[i];
      checks++; if (memory_done !== 1'b1) begin errors++; $display("FAIL ovr_done got %b expected 1", memory_done); end
    end
    for (int i = 0; i < 6; i++) begin
      set_mar({23'h0, addr[i]});
      Mem_Read = 1'b1; Mem_enable512x32 = 1'b1; #1;
      checks++; if (Mem_to_datapath_out !== mmem[addr[i]]) begin errors++; $display("FAIL preload_rd[%0d] got %h expected %h", addr[i], Mem_to_datapath_out, mmem[addr[i]]); end
      Mem_enable512x32 = 1'b0; #1;
      checks++; if (Mem_to_datapath_out !== 32'h0) begin errors++; $display("FAIL rd_disabled got %h expected 0", Mem_to_datapath_out); end
      idle();
    end
  endtask

  task automatic test_fetch_load();
    logic [31:0] v;
    write_reg(4'd2, 32'd499);
    set_pc(32'd0);
    PCout = 1'b1; IncPC = 1'b1; MARin = 1'b1; Zin = 1'b1; tick(); idle();
    checks++; if (MAR_address_out !== 9'd0) begin errors++; $display("FAIL fetch_mar got %h expected 0", MAR_address_out); end
    Zlo_out = 1'b1; PCin = 1'b1; MDRin = 1'b1; Mem_Read = 1'b1; Mem_enable512x32 = 1'b1; tick(); idle();
    MDRout = 1'b1; IRin = 1'b1; tick(); idle();
    PCout = 1'b1; outport_in = 1'b1; tick(); idle();
    checks++; if (outport_data !== 32'd1) begin errors++; $display("FAIL fetch_pc got %h expected 1", outport_data); end
    Cout = 1'b1; outport_in = 1'b1; tick(); idle();
    checks++; if (outport_data !== 32'd1) begin errors++; $display("FAIL fetch_ir_c got %h expected 1", outport_data); end
    // ld r1,1(r2) with IR = 0x18900001 already in place
    Grb = 1'b1; Rout = 1'b1; BAout = 1'b1; Yin = 1'b1; tick(); idle();
    Cout = 1'b1; Zin = 1'b1; opcode = 5'd3; tick(); idle();
    Zlo_out = 1'b1; MARin = 1'b1; tick(); idle();
    checks++; if (MAR_address_out !== 9'd500) begin errors++; $display("FAIL ld_mar got %0d expected 500", MAR_address_out); end
    MDRin = 1'b1; Mem_Read = 1'b1; Mem_enable512x32 = 1'b1; tick(); idle();
    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; tick(); idle();
    read_reg(4'd1, v);
    checks++; if (v !== mmem[500]) begin errors++; $display("FAIL ld_r1 got %h expected %h", v, mmem[500]); end
  endtask

  task automatic test_baout();
    write_reg(4'd0, 32'h55);
    set_ir(32'h0);
    for (int k = 0; k < 2; k++) begin
      Grb = 1'b1; Rout = 1'b1; BAout = (k == 0); Yin = 1'b1; tick(); idle();
      put_inport(32'h0);
      Inport_out = 1'b1; Zin = 1'b1; opcode = 5'd3; tick(); idle();
      Zlo_out = 1'b1; outport_in = 1'b1; tick(); idle();
      checks++;
      if (outport_data !== ((k == 0) ? 32'h0 : 32'h55)) begin
        errors++; $display("FAIL baout_y k=%0d got %h expected %h", k, outport_data, (k == 0) ? 32'h0 : 32'h55);
      end
    end
  endtask

  task automatic test_store();
    write_reg(4'd1, 32'd7);
    write_reg(4'd2, 32'd499);
    set_ir({5'b0, 4'd1, 4'd2, 19'd1});
    Grb = 1'b1; Rout = 1'b1; BAout = 1'b1; Yin = 1'b1; tick(); idle();
    Cout = 1'b1; Zin = 1'b1; opcode = 5'd3; tick(); idle();
    Zlo_out = 1'b1; MARin = 1'b1; tick(); idle();
    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; tick(); idle();
    checks++; if (Mem_data_to_chip_out !== 32'd7) begin errors++; $display("FAIL st_mdr got %h expected 7", Mem_data_to_chip_out); end
    checks++; if (memory_done !== 1'b0) begin errors++; $display("FAIL st_done_pre got %b expected 0", memory_done); end
    Mem_Write = 1'b1; Mem_enable512x32 = 1'b1; tick(); idle();
    mmem[500] = 32'd7;
    checks++; if (memory_done !== 1'b1) begin errors++; $display("FAIL st_done got %b expected 1", memory_done); end
    tick();
    checks++; if (memory_done !== 1'b0) begin errors++; $display("FAIL st_done_after got %b expected 0", memory_done); end
    Mem_Read = 1'b1; Mem_enable512x32 = 1'b1; #1;
    checks++; if (Mem_to_datapath_out !== mmem[500]) begin errors++; $display("FAIL st_readback got %h expected %h", Mem_to_datapath_out, mmem[500]); end
    idle();
  endtask

  task automatic test_alu();
    logic [4:0]  ops [7];
    logic [4:0]  op;
    logic [31:0] a, b;
    logic [63:0] e;
    ops[0] = 5'd3; ops[1] = 5'd4; ops[2] = 5'd5; ops[3] = 5'd6;
    ops[4] = 5'd7; ops[5] = 5'd8; ops[6] = 5'd15;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; b = $urandom;
      if (i % 8 == 7) op = 5'($urandom_range(0, 31));
      else op = ops[i % 7];
      e = ref_alu(op, a, b);
      put_inport(a);
      Inport_out = 1'b1; Yin = 1'b1; inport_data = b; inport_data_ready = 1'b1; tick(); idle();
      Inport_out = 1'b1; Zin = 1'b1; opcode = op; tick(); idle();
      Zlo_out = 1'b1; outport_in = 1'b1; tick(); idle();
      checks++; if (outport_data !== e[31:0]) begin errors++; $display("FAIL alu_lo op=%0d a=%h b=%h got %h expected %h", op, a, b, outport_data, e[31:0]); end
      Zhi_out = 1'b1; outport_in = 1'b1; tick(); idle();
      checks++; if (outport_data !== e[63:32]) begin errors++; $display("FAIL alu_hi op=%0d a=%h b=%h got %h expected %h", op, a, b, outport_data, e[63:32]); end
    end
  endtask

  task automatic test_incpc();
    logic [31:0] b;
    for (int i = 0; i < 4; i++) begin
      b = (i == 0) ? 32'hFFFF_FFFF : $urandom;
      put_inport(b);
      Inport_out = 1'b1; IncPC = 1'b1; Zin = 1'b1; opcode = 5'($urandom_range(0, 31)); tick(); idle();
      Zlo_out = 1'b1; outport_in = 1'b1; tick(); idle();
      checks++; if (outport_data !== b + 32'd1) begin errors++; $display("FAIL incpc_lo b=%h got %h expected %h", b, outport_data, b + 32'd1); end
      Zhi_out = 1'b1; outport_in = 1'b1; tick(); idle();
      checks++; if (outport_data !== 32'h0) begin errors++; $display("FAIL incpc_hi got %h expected 0", outport_data); end
    end
  endtask

  task automatic test_con();
    logic [1:0]  c2;
    logic [31:0] v;
    logic        e;
    for (int i = 0; i < 24; i++) begin
      c2 = 2'(i % 4);
      v  = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
      case (c2)
        2'd0: e = (v == 0);
        2'd1: e = (v != 0);
        2'd2: e = ($signed(v) >= 0);
        default: e = ($signed(v) < 0);
      endcase
      set_ir({11'b0, c2, 19'($urandom)});
      put_inport(v);
      Inport_out = 1'b1; CONin = 1'b1; tick(); idle();
      checks++; if (con_ff_bit !== e) begin errors++; $display("FAIL con c2=%0d bus=%h got %b expected %b", c2, v, con_ff_bit, e); end
    end
  endtask

  task automatic test_priority();
    put_inport(32'hA); Inport_out = 1'b1; HIin = 1'b1; tick(); idle();
    put_inport(32'hB); Inport_out = 1'b1; LOin = 1'b1; tick(); idle();
    set_pc(32'hC);
    put_inport(32'h20); Inport_out = 1'b1; IncPC = 1'b1; Zin = 1'b1; tick(); idle();
    put_inport(32'hD);
    Zlo_out = 1'b1; HIout = 1'b1; PCout = 1'b1; outport_in = 1'b1; tick(); idle();
    checks++; if (outport_data !== 32'h21) begin errors++; $display("FAIL prio_zlo got %h expected 21", outport_data); end
    Zhi_out = 1'b1; HIout = 1'b1; outport_in = 1'b1; tick(); idle();
    checks++; if (outport_data !== 32'h0) begin errors++; $display("FAIL prio_zhi got %h expected 0", outport_data); end
    HIout = 1'b1; LOout = 1'b1; PCout = 1'b1; outport_in = 1'b1; tick(); idle();
    checks++; if (outport_data !== 32'hA) begin errors++; $display("FAIL prio_hi got %h expected a", outport_data); end
    LOout = 1'b1; PCout = 1'b1; Inport_out = 1'b1; outport_in = 1'b1; tick(); idle();
    checks++; if (outport_data !== 32'hB) begin errors++; $display("FAIL prio_lo got %h expected b", outport_data); end
    PCout = 1'b1; Inport_out = 1'b1; outport_in = 1'b1; tick(); idle();
    checks++; if (outport_data !== 32'hC) begin errors++; $display("FAIL prio_pc got %h expected c", outport_data); end
    outport_in = 1'b1; tick(); idle();
    checks++; if (outport_data !== 32'h0) begin errors++; $display("FAIL bus_idle got %h expected 0", outport_data); end
  endtask

  task automatic test_mar_wrap();
    logic [31:0] v;
    for (int i = 0; i < 3; i++) begin
      v = $urandom | 32'h8000_0200;
      set_mar(v);
      checks++; if (MAR_address_out !== v[8:0]) begin errors++; $display("FAIL mar_wrap bus=%h got %h expected %h", v, MAR_address_out, v[8:0]); end
    end
  endtask

  task automatic test_rin_rout();
    logic [31:0] v, r;
    v = $urandom;
    write_reg(4'd5, v);
    Gra = 1'b1; Rout = 1'b1; Rin = 1'b1; IncPC = 1'b1; Zin = 1'b1; outport_in = 1'b1; tick(); idle();
    checks++; if (outport_data !== v) begin errors++; $display("FAIL rinrout_bus got %h expected %h", outport_data, v); end
    Zlo_out = 1'b1; outport_in = 1'b1; tick(); idle();
    checks++; if (outport_data !== v + 32'd1) begin errors++; $display("FAIL rinrout_z got %h expected %h", outport_data, v + 32'd1); end
    read_reg(4'd5, r);
    checks++; if (r !== v) begin errors++; $display("FAIL rinrout_reg got %h expected %h", r, v); end
  endtask

  task automatic test_clear_mid();
    logic [31:0] r;
    write_reg(4'd1, 32'd9);
    set_pc(32'd5);
    set_ir(32'h0007_FFFF);
    put_inport(32'h0); Inport_out = 1'b1; CONin = 1'b1; tick(); idle();
    put_inport(32'hABCD); Inport_out = 1'b1; outport_in = 1'b1; MARin = 1'b1; tick(); idle();
    PCout = 1'b1; IncPC = 1'b1; MARin = 1'b1; Zin = 1'b1; Mem_enable512x32 = 1'b1; tick();
    checks++; if (memory_done !== 1'b1) begin errors++; $display("FAIL pre_clear_done got %b expected 1", memory_done); end
    #2 clear = 1'b0;
    #1;
    checks++; if (outport_data !== 32'h0) begin errors++; $display("FAIL clear_outport got %h expected 0", outport_data); end
    checks++; if (memory_done !== 1'b0) begin errors++; $display("FAIL clear_done got %b expected 0", memory_done); end
    checks++; if (con_ff_bit !== 1'b0) begin errors++; $display("FAIL clear_con got %b expected 0", con_ff_bit); end
    checks++; if (MAR_address_out !== 9'h0) begin errors++; $display("FAIL clear_mar got %h expected 0", MAR_address_out); end
    idle();
    clear = 1'b1;
    PCout = 1'b1; outport_in = 1'b1; tick(); idle();
    checks++; if (outport_data !== 32'h0) begin errors++; $display("FAIL clear_pc got %h expected 0", outport_data); end
    Cout = 1'b1; outport_in = 1'b1; tick(); idle();
    checks++; if (outport_data !== 32'h0) begin errors++; $display("FAIL clear_ir got %h expected 0", outport_data); end
    read_reg(4'd1, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL clear_r1 got %h expected 0", r); end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_fetch_load();
    test_baout();
    test_store();
    test_alu();
    test_incpc();
    test_con();
    test_priority();
    test_mar_wrap();
    test_rin_rout();
    test_clear_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
